vga_frame_out: RTL and testbench
================================

# vga_frame_out

Final VGA output stage, directly downstream of the object priority mux. It owns the 640x480@60 raster counters and publishes the current pixel coordinates to every drawing object. It consumes the mux's registered 8-bit RGB332 pixel and realigns it with delayed sync and blank. It drives the DAC/connector pins with 8-bit-per-channel colour, hSync, vSync and blankN.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- MUX_LATENCY, 1: cycles from pixelX/pixelY to the matching RGBIn (range 1..4).

Ports:
- clk  in  1: pixel clock (25.175 MHz nominal); one pixel per cycle.
- reset  in  1: asynchronous, active-high.
- pixelX  out  11: current horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800).
- pixelY  out  11: current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525).
- startOfFrame  out  1: one-cycle pulse when the counters wrap to (0,0).
- RGBIn  in  8: RGB332 pixel from the object mux ({R[2:0],G[2:0],B[1:0]}).
- red, green, blue  out  8 each: expanded colour to the DAC.
- hSync, vSync  out  1 each: active-low syncs.
- blankN  out  1: high while the output pixel is visible.
- testPattern  in  1: present only with VGA_TEST_PATTERN_EN.

## Operation
- Counters: pixelX increments every cycle. At H_TOTAL-1 it wraps to 0 and pixelY increments. pixelY wraps to 0 at V_TOTAL-1 when pixelX wraps.
- pixelX and pixelY are registered and keep counting through blanking. Objects use them to decide visibility.
- startOfFrame is registered and high exactly during the cycle in which pixelX==0 and pixelY==0 after a wrap. There is no pulse on the first (0,0) after reset release.
- Raw timing, decoded from the counters:
  - active = pixelX<H_ACTIVE && pixelY<V_ACTIVE
  - hs = pixelX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - vs = pixelY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- active, hs and vs pass through a MUX_LATENCY-stage shift register, then one output register, so they align with the registered colour.
- Colour register:
  - When the delayed active is 1: red = {R,R,R[2:1]}, green = {G,G,G[2:1]}, blue = {B,B,B,B}.
  - When the delayed active is 0: red/green/blue = 0.
- hSync = ~hs_delayed, vSync = ~vs_delayed, blankN = active_delayed.
- All outputs are registered. There are no combinational paths from RGBIn to outputs.

## Timing
- Reset values:
  - pixelX=0, pixelY=0, startOfFrame=0.
  - Colour outputs 0.
  - hSync=1, vSync=1, blankN=0.
  - Delay-line contents are cleared to inactive.
- Reset asserted mid-frame: all of the above take effect immediately (async). Counting resumes from (0,0) on the first clk edge after deassertion.
- Latency: the output for counter value (x,y) appears MUX_LATENCY+1 cycles after pixelX/pixelY=(x,y). With default 1, that is 2 cycles.
- Line wrap and frame wrap occur in the same cycle at (799,524) → (0,0). startOfFrame rises in that (0,0) cycle.
- Sync edges are exact:
  - hSync is low for 96 consecutive cycles per line.
  - vSync is low for exactly 2×800 cycles per frame, aligned to pixelX=0 of line 490 (delayed).
- RGBIn is sampled every cycle. Its value during blanking is ignored.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - The testPattern port exists.
  - When testPattern=1, the colour register loads eight vertical colour bars, each 80 pixels wide, in place of RGBIn.
  - The bar index is the delayed pixelX[9:7]-equivalent: bar = x/80. Bar colours are white, yellow, cyan, green, magenta, red, blue, black, as full 8-bit 0xFF/0x00 channels.
  - Sync, blank and latency are unchanged.
- Not defined: no testPattern port; colour always derives from RGBIn.

## Test plan
- Reset held then released → all outputs at reset values. pixelX reads 0,1,2… on successive cycles. No startOfFrame until the first full frame (420,000 cycles) completes.
- Count one line → hSync low for exactly 96 cycles, starting 658 cycles after pixelX=0 (default latency); 800-cycle period.
- Count one frame → vSync low for 1600 cycles beginning at delayed line 490. startOfFrame pulses once per 420,000 cycles.
- Alignment: drive RGBIn=8'hE0 only during the cycle one after pixelX=5, pixelY=0 → red=8'hFF appears only in the output cycle for x=5, with blankN=1.
- Expansion: RGBIn=8'b101_010_01 in the active area → red=8'hB6, green=8'h49, blue=8'h55. The same value during blanking → all 0.
- With VGA_TEST_PATTERN_EN, testPattern=1 → x=0..79 gives FF/FF/FF; x=80 gives FF/FF/00; x=560..639 gives 00/00/00. Async reset at x=300,y=200 → outputs return to reset values immediately.

Source files
------------

// File: rtl/vga_frame_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_out_if
//  Description : Pixel-coordinate / colour bundle between the raster output
//                stage (master) and the object mux plus DAC pins (slave).
//                testPattern exists only when VGA_TEST_PATTERN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_out_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  RGBIn;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hSync;
    logic        vSync;
    logic        blankN;
`ifdef VGA_TEST_PATTERN_EN
    logic        testPattern;
`endif

    // Output stage side: owns the counters and the DAC pins
    modport master (
        output pixelX, pixelY, startOfFrame,
        output red, green, blue, hSync, vSync, blankN,
`ifdef VGA_TEST_PATTERN_EN
        input  testPattern,
`endif
        input  RGBIn
    );

    // Mux / connector side
    modport slave (
        input  pixelX, pixelY, startOfFrame,
        input  red, green, blue, hSync, vSync, blankN,
`ifdef VGA_TEST_PATTERN_EN
        output testPattern,
`endif
        output RGBIn
    );
endinterface
`default_nettype wire

// File: rtl/vga_frame_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_out
//  Description : Final VGA output stage. Owns the raster counters, publishes
//                pixelX/pixelY, delays active/hsync/vsync to line up with the
//                mux's registered RGB332 pixel and expands it to 8:8:8.
//                Optional colour-bar generator: VGA_TEST_PATTERN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_out #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MUX_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    vga_frame_out_if.master bus
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_x_last     = 11'(c_h_total - 1);
    localparam logic [10:0] c_y_last     = 11'(c_v_total - 1);
    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_first   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_last    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_vs_first   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_last    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int          c_bar_width  = 80;

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_sof;

    logic        w_active;
    logic        w_hs;
    logic        w_vs;

    logic [MUX_LATENCY-1:0] r_act_dly;
    logic [MUX_LATENCY-1:0] r_hs_dly;
    logic [MUX_LATENCY-1:0] r_vs_dly;

    logic [7:0]  w_red;
    logic [7:0]  w_green;
    logic [7:0]  w_blue;

    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;

    // Raster counters; startOfFrame flags the (0,0) reached by a wrap only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x   <= 11'd0;
            r_y   <= 11'd0;
            r_sof <= 1'b0;
        end else begin
            r_sof <= (r_x == c_x_last) && (r_y == c_y_last);
            if (r_x == c_x_last) begin
                r_x <= 11'd0;
                r_y <= (r_y == c_y_last) ? 11'd0 : r_y + 11'd1;
            end else begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    // Raw timing decoded from the current counter values
    always_comb begin
        w_active = (r_x < c_h_active) && (r_y < c_v_active);
        w_hs     = (r_x >= c_hs_first) && (r_x <= c_hs_last);
        w_vs     = (r_y >= c_vs_first) && (r_y <= c_vs_last);
    end

    // Delay lines matching the object mux latency; stage [MUX_LATENCY-1]
    // lines up with the RGBIn that belongs to the same coordinate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_dly <= '0;
            r_hs_dly  <= '0;
            r_vs_dly  <= '0;
        end else begin
            for (int i = MUX_LATENCY - 1; i > 0; i--) begin
                r_act_dly[i] <= r_act_dly[i-1];
                r_hs_dly[i]  <= r_hs_dly[i-1];
                r_vs_dly[i]  <= r_vs_dly[i-1];
            end
            r_act_dly[0] <= w_active;
            r_hs_dly[0]  <= w_hs;
            r_vs_dly[0]  <= w_vs;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;
    logic [2:0] r_bar_dly [MUX_LATENCY];
    logic [2:0] w_bar_rgb;

    // Bar index = x / 80, built from threshold compares instead of a divider
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_x >= 11'(k * c_bar_width)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Bar index follows the same delay as the active flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUX_LATENCY; i++) begin
                r_bar_dly[i] <= 3'd0;
            end
        end else begin
            for (int i = MUX_LATENCY - 1; i > 0; i--) begin
                r_bar_dly[i] <= r_bar_dly[i-1];
            end
            r_bar_dly[0] <= w_bar;
        end
    end

    // Bar colour as {R,G,B} on/off: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        w_bar_rgb = 3'b000;
        case (r_bar_dly[MUX_LATENCY-1])
            3'd0:    w_bar_rgb = 3'b111;
            3'd1:    w_bar_rgb = 3'b110;
            3'd2:    w_bar_rgb = 3'b011;
            3'd3:    w_bar_rgb = 3'b010;
            3'd4:    w_bar_rgb = 3'b101;
            3'd5:    w_bar_rgb = 3'b100;
            3'd6:    w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end
`endif

    // Next colour: RGB332 replicated to 8 bits, forced black outside the active area
    always_comb begin
        w_red   = 8'h00;
        w_green = 8'h00;
        w_blue  = 8'h00;
        if (r_act_dly[MUX_LATENCY-1]) begin
`ifdef VGA_TEST_PATTERN_EN
            if (bus.testPattern) begin
                w_red   = {8{w_bar_rgb[2]}};
                w_green = {8{w_bar_rgb[1]}};
                w_blue  = {8{w_bar_rgb[0]}};
            end else begin
                w_red   = {bus.RGBIn[7:5], bus.RGBIn[7:5], bus.RGBIn[7:6]};
                w_green = {bus.RGBIn[4:2], bus.RGBIn[4:2], bus.RGBIn[4:3]};
                w_blue  = {4{bus.RGBIn[1:0]}};
            end
`else
            w_red   = {bus.RGBIn[7:5], bus.RGBIn[7:5], bus.RGBIn[7:6]};
            w_green = {bus.RGBIn[4:2], bus.RGBIn[4:2], bus.RGBIn[4:3]};
            w_blue  = {4{bus.RGBIn[1:0]}};
`endif
        end
    end

    // Output register: colour, syncs (active-low) and blank leave together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_red     <= 8'h00;
            r_green   <= 8'h00;
            r_blue    <= 8'h00;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_red     <= w_red;
            r_green   <= w_green;
            r_blue    <= w_blue;
            r_hsync   <= ~r_hs_dly[MUX_LATENCY-1];
            r_vsync   <= ~r_vs_dly[MUX_LATENCY-1];
            r_blank_n <= r_act_dly[MUX_LATENCY-1];
        end
    end

    assign bus.pixelX       = r_x;
    assign bus.pixelY       = r_y;
    assign bus.startOfFrame = r_sof;
    assign bus.red          = r_red;
    assign bus.green        = r_green;
    assign bus.blue         = r_blue;
    assign bus.hSync        = r_hsync;
    assign bus.vSync        = r_vsync;
    assign bus.blankN       = r_blank_n;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_frame_out
//  Description : Directed self-checking bench. Instance A uses 640x480 timing
//                for line-level checks; instance B uses a tiny raster
//                (32x12, MUX_LATENCY=3) so whole frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_out;

    logic clk;
    logic reset;

    vga_frame_out_if bus_a ();
    vga_frame_out_if bus_b ();

    vga_frame_out u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vga_frame_out #(
        .H_ACTIVE    (20),
        .H_FP        (4),
        .H_SYNC      (6),
        .H_BP        (2),
        .V_ACTIVE    (6),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (2),
        .MUX_LATENCY (3)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int a_hs_fall1 = -1;
    int a_hs_fall2 = -1;
    int a_hs_low   = 0;
    int a_sof_cnt  = 0;
    int b_hs_fall1 = -1;
    int b_hs_low   = 0;
    int b_vs_fall1 = -1;
    int b_vs_low   = 0;
    int b_sof_cnt  = 0;
    int b_sof_first = -1;
    logic a_hs_prev;
    logic b_hs_prev;
    logic b_vs_prev;

    initial begin
        reset       = 1'b1;
        bus_a.RGBIn = 8'h00;
        bus_b.RGBIn = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
        bus_a.testPattern = 1'b0;
        bus_b.testPattern = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_pixelX",  32'(bus_a.pixelX), 32'd0);
        check("rst_pixelY",  32'(bus_a.pixelY), 32'd0);
        check("rst_sof",     32'(bus_a.startOfFrame), 32'd0);
        check("rst_rgb",     32'({bus_a.red, bus_a.green, bus_a.blue}), 32'h0);
        check("rst_syncs",   32'({bus_a.hSync, bus_a.vSync, bus_a.blankN}), 32'b110);

        reset = 1'b0;
        a_hs_prev = 1'b1;
        b_hs_prev = 1'b1;
        b_vs_prev = 1'b1;

        for (int c = 0; c < 1700; c++) begin
            if (c > 0) @(negedge clk);

            // ---- point checks (instance A, latency 2) ----
            if (c < 4) begin
                check("a_pixelX_count", 32'(bus_a.pixelX), 32'(c));
                check("b_pixelX_count", 32'(bus_b.pixelX), 32'(c));
            end
            if (c == 1) check("a_blank_lat1", 32'(bus_a.blankN), 32'd0);
            if (c == 2) check("a_blank_lat2", 32'(bus_a.blankN), 32'd1);
            if (c == 3) check("b_blank_lat3", 32'(bus_b.blankN), 32'd0);
            if (c == 4) check("b_blank_lat4", 32'(bus_b.blankN), 32'd1);
            if (c == 6) check("align_before", 32'({bus_a.red, 7'd0, bus_a.blankN}), 32'h0001);
            if (c == 7) check("align_x5",     32'({bus_a.red, 7'd0, bus_a.blankN}), 32'hFF01);
            if (c == 8) check("align_after",  32'({bus_a.red, 7'd0, bus_a.blankN}), 32'h0001);
            if (c == 21)  check("expand_active", 32'({bus_a.red, bus_a.green, bus_a.blue}), 32'hB64955);
            if (c == 701) check("expand_blank",  32'({bus_a.red, bus_a.green, bus_a.blue, 7'd0, bus_a.blankN}), 32'h0);
            if (c == 800) check("a_line_wrap",   32'({bus_a.pixelY, 5'd0, bus_a.pixelX}), 32'h0001_0000);
            if (c == 383) check("b_last_pixel",  32'({bus_b.pixelY, 5'd0, bus_b.pixelX}), 32'h000B_001F);
            if (c == 384) check("b_frame_wrap",  32'({bus_b.pixelY, bus_b.pixelX, 1'b0, bus_b.startOfFrame}), 32'h1);
`ifdef VGA_TEST_PATTERN_EN
            if (c == 802)  check("tp_x0",   32'({bus_a.red, bus_a.green, bus_a.blue}), 32'hFFFFFF);
            if (c == 881)  check("tp_x79",  32'({bus_a.red, bus_a.green, bus_a.blue}), 32'hFFFFFF);
            if (c == 882)  check("tp_x80",  32'({bus_a.red, bus_a.green, bus_a.blue}), 32'hFFFF00);
            if (c == 962)  check("tp_x160", 32'({bus_a.red, bus_a.green, bus_a.blue}), 32'h00FFFF);
            if (c == 1362) check("tp_x560", 32'({bus_a.red, bus_a.green, bus_a.blue, 7'd0, bus_a.blankN}), 32'h1);
            if (c == 1441) check("tp_x639", 32'({bus_a.red, bus_a.green, bus_a.blue, 7'd0, bus_a.blankN}), 32'h1);
`endif
            if (c == 1699) check("pre_reset_red", 32'(bus_a.red), 32'hFF);

            // ---- edge/run measurements ----
            if (a_hs_prev && !bus_a.hSync) begin
                if (a_hs_fall1 < 0) a_hs_fall1 = c;
                else if (a_hs_fall2 < 0) a_hs_fall2 = c;
            end
            if (!bus_a.hSync && c < 1600) a_hs_low++;
            if (bus_a.startOfFrame) a_sof_cnt++;
            if (b_hs_prev && !bus_b.hSync && b_hs_fall1 < 0) b_hs_fall1 = c;
            if (!bus_b.hSync && c < 60) b_hs_low++;
            if (b_vs_prev && !bus_b.vSync && b_vs_fall1 < 0) b_vs_fall1 = c;
            if (!bus_b.vSync && c < 384) b_vs_low++;
            if (bus_b.startOfFrame) begin
                b_sof_cnt++;
                if (b_sof_first < 0) b_sof_first = c;
            end
            a_hs_prev = bus_a.hSync;
            b_hs_prev = bus_b.hSync;
            b_vs_prev = bus_b.vSync;

            // ---- stimulus for this cycle ----
            case (c)
                6:    bus_a.RGBIn = 8'hE0;
                20:   bus_a.RGBIn = 8'hA9;
                700:  bus_a.RGBIn = 8'hA9;
                1690: bus_a.RGBIn = 8'hFF;
                7, 21, 701: bus_a.RGBIn = 8'h00;
                default: ;
            endcase
`ifdef VGA_TEST_PATTERN_EN
            if (c == 800)  bus_a.testPattern = 1'b1;
            if (c == 1600) bus_a.testPattern = 1'b0;
`endif
        end

        check("a_hs_first_fall", 32'(a_hs_fall1), 32'd658);
        check("a_hs_second_fall", 32'(a_hs_fall2), 32'd1458);
        check("a_hs_low_cycles", 32'(a_hs_low), 32'd192);
        check("a_no_early_sof", 32'(a_sof_cnt), 32'd0);
        check("b_hs_first_fall", 32'(b_hs_fall1), 32'd28);
        check("b_hs_low_cycles", 32'(b_hs_low), 32'd6);
        check("b_vs_first_fall", 32'(b_vs_fall1), 32'd260);
        check("b_vs_low_cycles", 32'(b_vs_low), 32'd64);
        check("b_sof_first", 32'(b_sof_first), 32'd384);
        check("b_sof_count", 32'(b_sof_cnt), 32'd4);

        // Asynchronous reset mid-line: outputs must drop without a clock edge
        #2 reset = 1'b1;
        #1;
        check("async_pixelXY", 32'({bus_a.pixelY, bus_a.pixelX}), 32'h0);
        check("async_rgb",     32'({bus_a.red, bus_a.green, bus_a.blue}), 32'h0);
        check("async_syncs",   32'({bus_a.hSync, bus_a.vSync, bus_a.blankN}), 32'b110);
        check("async_b_xy",    32'({bus_b.pixelY, bus_b.pixelX}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("resume_x0", 32'(bus_a.pixelX), 32'd0);
        @(negedge clk);
        check("resume_x1", 32'(bus_a.pixelX), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
